// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings and bit-rate derivation.
package uart_pkg;

    localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_DATA      = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;

    function automatic int calc_divisor(input int clkfreq, input int baud);
        return clkfreq / baud;
    endfunction

    function automatic int calc_half(input int divisor);
        return divisor / 2;
    endfunction

    // Counter width able to hold DIVISOR-1.
    function automatic int timer_width(input int divisor);
        return $clog2(divisor) + 1;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: loadable, decrements to zero and holds, flags zero.
module uart_bit_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: mid-bit sampling FSM, shift register and single-entry holding register.
//   state        | meaning
//   ST_WAIT_IDLE | wait for line high before arming (after reset or framing error)
//   ST_IDLE      | armed, waiting for falling start edge
//   ST_START     | timing to middle of start bit to confirm it
//   ST_DATA      | sampling 8 data bits, LSB first
//   ST_STOP      | sampling stop bit
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CLKFREQ = 48000000,
    parameter int BAUD    = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIVISOR = calc_divisor(CLKFREQ, BAUD);
    localparam int HALF    = calc_half(DIVISOR);
    localparam int TW      = timer_width(DIVISOR);
    localparam logic [TW-1:0] LD_HALF = TW'(HALF - 1);
    localparam logic [TW-1:0] LD_BIT  = TW'(DIVISOR - 1);

    logic [2:0]    r_state;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_frame_err;
    logic          r_overrun;

    logic          w_zero;
    logic          w_load;
    logic [TW-1:0] w_load_val;
    logic          w_complete;
    logic          w_stop_bad;

    uart_bit_timer #(.WIDTH(TW)) u_bit_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // No reload on the stop sample: the frame ends there.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = LD_BIT;
        case (r_state)
            ST_IDLE: begin
                if (!rxd) begin
                    w_load     = 1'b1;
                    w_load_val = LD_HALF;
                end
            end
            ST_START: w_load = w_zero && !rxd;
            ST_DATA:  w_load = w_zero;
            default:  w_load = 1'b0;
        endcase
    end

    assign w_complete = (r_state == ST_STOP) && w_zero && rxd;
    assign w_stop_bad = (r_state == ST_STOP) && w_zero && !rxd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_WAIT_IDLE;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            case (r_state)
                ST_WAIT_IDLE: if (rxd) r_state <= ST_IDLE;
                ST_IDLE:      if (!rxd) r_state <= ST_START;
                ST_START: begin
                    if (w_zero) begin
                        if (!rxd) begin
                            r_state <= ST_DATA;
                            r_idx   <= 3'd0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_zero) begin
                        r_shift <= {rxd, r_shift[7:1]};
                        if (r_idx == 3'd7) r_state <= ST_STOP;
                        else               r_idx   <= r_idx + 3'd1;
                    end
                end
                ST_STOP: if (w_zero) r_state <= rxd ? ST_IDLE : ST_WAIT_IDLE;
                default: r_state <= ST_WAIT_IDLE;
            endcase
        end
    end

    // A byte completing while the consumer accepts the old one replaces it seamlessly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            r_overrun   <= w_complete && r_valid && !ready;
            if (w_complete && (!r_valid || ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: table-driven frames with a byte scoreboard plus hand-written corner cases.
module tb_uart_rx_deser;

    localparam int DIV0 = 16;
    localparam int DIV1 = 48000000 / 115200;

    logic       clk = 1'b0;
    logic       rst0, rxd0, ready0, valid0, ferr0, ovr0;
    logic       rst1, rxd1, ready1, valid1, ferr1, ovr1;
    logic [7:0] data0, data1;

    always #5 clk = ~clk;

    uart_rx_deser #(.CLKFREQ(16), .BAUD(1)) u_dut0 (
        .clk(clk), .reset(rst0), .rxd(rxd0), .data(data0), .valid(valid0),
        .ready(ready0), .frame_err(ferr0), .overrun(ovr0)
    );

    uart_rx_deser u_dut1 (
        .clk(clk), .reset(rst1), .rxd(rxd1), .data(data1), .valid(valid1),
        .ready(ready1), .frame_err(ferr1), .overrun(ovr1)
    );

    int checks = 0;
    int failures = 0;
    int ferr0_cnt = 0, ovr0_cnt = 0, ferr1_cnt = 0, ovr1_cnt = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard/monitor for each DUT, sampled 1 time unit after the falling edge.
    logic       pv0 = 0, pr0 = 0, pf0 = 0, po0 = 0;
    logic [7:0] pd0 = 0;
    always @(negedge clk) begin
        #1;
        if (valid0 && ready0) begin
            if (q0.size() == 0) begin
                checks++; failures++;
                $display("FAIL rx0_unexpected actual=%0h required=none", data0);
            end else begin
                check("rx0_data", {24'h0, data0}, {24'h0, q0.pop_front()});
            end
        end
        if (pv0 && !pr0 && valid0) check("rx0_hold_stable", {24'h0, data0}, {24'h0, pd0});
        if (ferr0) begin
            ferr0_cnt++;
            if (pf0) check("rx0_ferr_width", 32'd2, 32'd1);
        end
        if (ovr0) begin
            ovr0_cnt++;
            if (po0) check("rx0_ovr_width", 32'd2, 32'd1);
        end
        pv0 = valid0; pr0 = ready0; pd0 = data0; pf0 = ferr0; po0 = ovr0;
    end

    logic pf1 = 0, po1 = 0;
    always @(negedge clk) begin
        #1;
        if (valid1 && ready1) begin
            if (q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL rx1_unexpected actual=%0h required=none", data1);
            end else begin
                check("rx1_data", {24'h0, data1}, {24'h0, q1.pop_front()});
            end
        end
        if (ferr1) begin
            ferr1_cnt++;
            if (pf1) check("rx1_ferr_width", 32'd2, 32'd1);
        end
        if (ovr1) begin
            ovr1_cnt++;
            if (po1) check("rx1_ovr_width", 32'd2, 32'd1);
        end
        pf1 = ferr1; po1 = ovr1;
    end

    // Drive one frame on rxd0, starting at a falling edge; cycle 0 is the start-bit cycle.
    task automatic send0(input logic [7:0] b, input logic stop, input int rdy_pulse,
                         input bit chk_timing, input int ncyc);
        int bi;
        for (int c = 0; c < ncyc; c++) begin
            bi = c / DIV0;
            if (bi == 0)      rxd0 = 1'b0;
            else if (bi <= 8) rxd0 = b[bi-1];
            else              rxd0 = stop;
            if (rdy_pulse >= 0 && c == rdy_pulse)     ready0 = 1'b1;
            if (rdy_pulse >= 0 && c == rdy_pulse + 1) ready0 = 1'b0;
            if (chk_timing && c >= 150 && c <= 156)
                check($sformatf("valid_timing_c%0d", c), {31'h0, valid0}, {31'h0, (c == 153)});
            @(negedge clk);
        end
        rxd0 = 1'b1;
    endtask

    task automatic send1(input logic [7:0] b);
        int bi;
        for (int c = 0; c < 10 * DIV1; c++) begin
            bi = c / DIV1;
            if (bi == 0)      rxd1 = 1'b0;
            else if (bi <= 8) rxd1 = b[bi-1];
            else              rxd1 = 1'b1;
            @(negedge clk);
        end
        rxd1 = 1'b1;
    endtask

    typedef struct {
        logic [7:0] b;
        logic       rdy;
        int         exp_ovr;
        logic       exp_v;
        logic [7:0] exp_d;
    } vec_t;

    vec_t vecs[9];
    logic [7:0] bytes1[12];

    initial begin
        int ov_before, fe_before;
        bit held;

        vecs[0] = '{8'h3C, 1'b0, 0, 1'b1, 8'h3C};
        vecs[1] = '{8'hC3, 1'b0, 1, 1'b1, 8'h3C};
        vecs[2] = '{8'h5A, 1'b1, 0, 1'b0, 8'h00};
        vecs[3] = '{8'h0F, 1'b1, 0, 1'b0, 8'h00};
        vecs[4] = '{8'hF0, 1'b1, 0, 1'b0, 8'h00};
        vecs[5] = '{8'h00, 1'b1, 0, 1'b0, 8'h00};
        vecs[6] = '{8'hFF, 1'b1, 0, 1'b0, 8'h00};
        vecs[7] = '{8'h66, 1'b0, 0, 1'b1, 8'h66};
        vecs[8] = '{8'h99, 1'b0, 1, 1'b1, 8'h66};
        bytes1 = '{8'h00, 8'h01, 8'h02, 8'h55, 8'h7F, 8'h80,
                   8'hA5, 8'hAA, 8'hC3, 8'hFD, 8'hFE, 8'hFF};

        rst0 = 1'b1; rst1 = 1'b1; rxd0 = 1'b1; rxd1 = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data0",  {24'h0, data0}, 32'h0);
        check("rst_valid0", {31'h0, valid0}, 32'h0);
        check("rst_ferr0",  {31'h0, ferr0}, 32'h0);
        check("rst_ovr0",   {31'h0, ovr0}, 32'h0);
        check("rst_valid1", {31'h0, valid1}, 32'h0);
        rst0 = 1'b0; rst1 = 1'b0;
        repeat (3) @(negedge clk);

        // Latency: valid exactly in cycle HALF+9*DIVISOR+1 = 153, for one cycle.
        q0.push_back(8'hA5);
        send0(8'hA5, 1'b1, -1, 1'b1, 160);
        repeat (4) @(negedge clk);

        held = 0;
        for (int i = 0; i < 9; i++) begin
            ready0 = vecs[i].rdy;
            if (vecs[i].rdy) held = 0;
            ov_before = ovr0_cnt;
            if (!(held && !vecs[i].rdy)) begin
                q0.push_back(vecs[i].b);
                if (!vecs[i].rdy) held = 1;
            end
            send0(vecs[i].b, 1'b1, -1, 1'b0, 160);
            repeat (4) @(negedge clk);
            check($sformatf("vec%0d_overrun", i), ovr0_cnt - ov_before, vecs[i].exp_ovr);
            check($sformatf("vec%0d_valid", i), {31'h0, valid0}, {31'h0, vecs[i].exp_v});
            if (vecs[i].exp_v)
                check($sformatf("vec%0d_data", i), {24'h0, data0}, {24'h0, vecs[i].exp_d});
        end

        // Consumer accepts the held byte in the very cycle a new one completes.
        ov_before = ovr0_cnt;
        q0.push_back(8'h22);
        send0(8'h22, 1'b1, 152, 1'b0, 160);
        repeat (2) @(negedge clk);
        check("sameclk_overrun", ovr0_cnt - ov_before, 0);
        check("sameclk_valid", {31'h0, valid0}, 32'h1);
        check("sameclk_data", {24'h0, data0}, 32'h22);
        ready0 = 1'b1;
        repeat (4) @(negedge clk);

        // Bad stop bit with the line held low for 20 bit times.
        fe_before = ferr0_cnt;
        rxd0 = 1'b0;
        repeat (20 * DIV0) @(negedge clk);
        rxd0 = 1'b1;
        repeat (10) @(negedge clk);
        check("ferr_count", ferr0_cnt - fe_before, 1);
        check("ferr_valid", {31'h0, valid0}, 32'h0);
        q0.push_back(8'h55);
        send0(8'h55, 1'b1, -1, 1'b0, 160);
        repeat (4) @(negedge clk);
        check("ferr_after_count", ferr0_cnt - fe_before, 1);

        // Four-cycle glitch low is rejected at mid-start sample.
        rxd0 = 1'b0;
        repeat (4) @(negedge clk);
        rxd0 = 1'b1;
        repeat (20) @(negedge clk);
        check("false_start_valid", {31'h0, valid0}, 32'h0);
        q0.push_back(8'h81);
        send0(8'h81, 1'b1, -1, 1'b0, 160);
        repeat (4) @(negedge clk);

        // Reset during data bit 4 of 0xFF, line then held low.
        fe_before = ferr0_cnt;
        ov_before = ovr0_cnt;
        send0(8'hFF, 1'b1, -1, 1'b0, 88);
        rst0 = 1'b1; rxd0 = 1'b0;
        @(negedge clk);
        check("midrst_data",  {24'h0, data0}, 32'h0);
        check("midrst_valid", {31'h0, valid0}, 32'h0);
        check("midrst_ferr",  {31'h0, ferr0}, 32'h0);
        check("midrst_ovr",   {31'h0, ovr0}, 32'h0);
        repeat (4) @(negedge clk);
        rst0 = 1'b0;
        repeat (100) @(negedge clk);
        check("lowline_valid", {31'h0, valid0}, 32'h0);
        check("lowline_ferr", ferr0_cnt - fe_before, 0);
        check("lowline_ovr", ovr0_cnt - ov_before, 0);
        rxd0 = 1'b1;
        repeat (2) @(negedge clk);
        q0.push_back(8'h12);
        send0(8'h12, 1'b1, -1, 1'b0, 160);

        for (int t = 0; t < 50 && q0.size() != 0; t++) @(negedge clk);
        check("rx0_queue_empty", q0.size(), 0);

        // Default rate, back-to-back frames.
        for (int i = 0; i < 12; i++) begin
            q1.push_back(bytes1[i]);
            send1(bytes1[i]);
        end
        for (int t = 0; t < 1000 && q1.size() != 0; t++) @(negedge clk);
        check("rx1_queue_empty", q1.size(), 0);
        check("rx1_ferr", ferr1_cnt, 0);
        check("rx1_ovr", ovr1_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_deser.md
UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001 SHALL have parameter CLKFREQ, default 48000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line bit rate; DIVISOR = CLKFREQ/BAUD (truncated), HALF = DIVISOR/2 (truncated).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rxd  input  1  already-synchronised, glitch-filtered serial line from the input filter stage, idle high.
REQ-006 SHALL have port data  output  8  received byte, valid while valid=1.
REQ-007 SHALL have port valid  output  1  holding register contains an unread byte.
REQ-008 SHALL have port ready  input  1  consumer accepts data this cycle when valid=1.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse: completed byte dropped because the holding register was full.

Function
REQ-011 SHALL receive 8N1 frames: start bit 0, 8 data bits LSB first, one stop bit 1.
REQ-012 SHALL implement states WAIT_IDLE, IDLE, START, DATA, STOP.
REQ-013 WAIT_IDLE SHALL go to IDLE on the first cycle rxd=1.
REQ-014 IDLE with rxd=0 SHALL load bit counter with HALF-1 and enter START; cycle of this detection is cycle 0.
REQ-015 Bit counter SHALL decrement each cycle; a sample occurs on the cycle it equals 0, then it reloads DIVISOR-1 unless leaving the frame.
REQ-016 START sample (cycle HALF): rxd=0 -> DATA with bit index 0; rxd=1 -> IDLE, false start, no outputs.
REQ-017 DATA sample k (cycle HALF+k*DIVISOR, k=1..8) SHALL shift rxd into shift-register MSB (shift right); after k=8 enter STOP.
REQ-018 STOP sample (cycle HALF+9*DIVISOR): rxd=1 -> byte completes, enter IDLE; rxd=0 -> frame_err=1 next cycle, byte discarded, enter WAIT_IDLE.
REQ-019 Completed byte SHALL load data and set valid on the following cycle (HALF+9*DIVISOR+1) when valid=0, or when valid=1 and ready=1 in the completion cycle.
REQ-020 valid SHALL clear on a cycle with valid=1 and ready=1 unless a byte is loaded in that same cycle (then valid stays 1, new data, no overrun).
REQ-021 Completion with valid=1 and ready=0 SHALL pulse overrun for one cycle, keep old data, drop new byte.
REQ-022 data SHALL hold stable while valid=1 and ready=0.
REQ-023 Receiver SHALL keep sampling the next frame regardless of valid/ready (no backpressure on the line).
REQ-024 frame_err and overrun SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-025 While reset=1: state WAIT_IDLE, counters 0, shift register 0, data=0, valid=0, frame_err=0, overrun=0.
REQ-026 reset asserted mid-frame SHALL abort the frame with no valid, frame_err or overrun.
REQ-027 After reset release with rxd held low, no frame SHALL start until rxd has been high at least one cycle.

Structure
REQ-028 State encoding constants and the DIVISOR/HALF derivation SHALL live in a shared UART package/header reused by the transmitter.
REQ-029 The bit timer (load/decrement/zero-flag) SHALL be a sub-module uart_bit_timer; the FSM, shift register and holding register stay in uart_rx_deser.

Verification
REQ-030 CLKFREQ=16, BAUD=1 (DIVISOR 16, HALF 8), ready=1, send 0xA5 -> data=0xA5, valid high exactly cycle 153 after the start edge, one cycle.
REQ-031 Same params, ready=0, send 0x3C then 0xC3 -> data stays 0x3C, valid stays 1, overrun pulses once at second completion.
REQ-032 Send frame with stop bit 0 (byte 0x00, line held low 20 bit times) -> frame_err single pulse, valid stays 0, next frame 0x55 after line returns high received correctly.
REQ-033 rxd low for 4 cycles then high -> false start, back to IDLE, no outputs; following 0x81 frame received correctly.
REQ-034 Assert reset during DATA bit 4 of a 0xFF frame with rxd low afterwards -> outputs 0, no frame starts until rxd high, then 0x12 frame received.
REQ-035 Default params, back-to-back 0x00..0xFF at 115200 with ready=1 -> all 256 bytes in order, no frame_err or overrun.
